// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential divider: default width and FSM states.
package seq_divider32_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider32_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, select.
module div_step #(
  parameter int WIDTH = seq_divider32_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted remainder can reach 2^WIDTH, so the compare/subtract is WIDTH+1 wide.
  // With shifted[WIDTH] set the value already exceeds any divisor; otherwise the
  // top bit of the trial difference is the borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = shifted[WIDTH] | ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider32.sv
// Unsigned sequential restoring divider, one quotient bit per cycle, MSB first.
module seq_divider32
  import seq_divider32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;       // remaining dividend bits; quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;      // partial remainder
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == CALC);
  assign done = (state == DONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem),
    .bit_in  (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a zero divisor short-circuits straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers (results move only on DONE entry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt  <= '0;
          dvd  <= dividend;
          dvs  <= divisor;
          prem <= '0;
          if (divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend;
            div_zero  <= 1'b1;
          end
        end
        CALC: begin
          dvd  <= {dvd[WIDTH-2:0], step_q};
          prem <= step_rem;
          cnt  <= cnt + 1'b1;
          if (last) begin
            quotient  <= {dvd[WIDTH-2:0], step_q};
            remainder <= step_rem;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider32.md
SEQ_DIVIDER32 -- requirements
Module: seq_divider32

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; the design SHALL be correct for WIDTH = 32 and SHALL be written generically.
REQ-002 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: request a new division; sampled only in IDLE.
REQ-005 Port dividend, input, WIDTH: unsigned numerator, captured on the accepting edge.
REQ-006 Port divisor, input, WIDTH: unsigned denominator, captured on the accepting edge.
REQ-007 Port busy, output, 1: high while in CALC.
REQ-008 Port done, output, 1: one-cycle pulse when quotient/remainder become valid.
REQ-009 Port quotient, output, WIDTH: result, held until the next accepted start.
REQ-010 Port remainder, output, WIDTH: result, held until the next accepted start.
REQ-011 Port div_zero, output, 1: set with done when divisor was 0; held like results.

Function
REQ-012 Algorithm: unsigned restoring division, MSB first, one quotient bit per CALC cycle.
REQ-013 FSM states: IDLE, CALC, DONE; encoding is 2 bits.
REQ-014 IDLE: start=1 at a rising edge -> capture operands, clear iteration counter to 0, go to CALC; otherwise stay.
REQ-015 IDLE with start=1 and divisor=0 -> go directly to DONE; quotient = all ones, remainder = dividend, div_zero = 1.
REQ-016 CALC, per cycle: partial remainder P = {P[WIDTH-2:0], next dividend bit}; if P >= divisor then P = P - divisor and the quotient bit is 1, else the quotient bit is 0.
REQ-017 The subtraction SHALL use WIDTH+1 bits so that P >= 2^(WIDTH-1) cases are correct.
REQ-018 The counter SHALL run 0..WIDTH-1; after the cycle with counter = WIDTH-1, go to DONE.
REQ-019 DONE: done = 1 for exactly one cycle; quotient/remainder are valid in that cycle; next state is IDLE.
REQ-020 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH (33 edges for WIDTH = 32); the divide-by-zero path -> done high after edge k.
REQ-021 start asserted while in CALC or DONE SHALL be ignored; captured operands SHALL be unaffected.
REQ-022 start held high continuously SHALL start a new division from each IDLE cycle, i.e. back-to-back operations.
REQ-023 quotient, remainder and div_zero SHALL change only on DONE entry, and SHALL be stable in IDLE and CALC.
REQ-024 Input changes after the accepting edge SHALL NOT affect the result.

Reset
REQ-025 rst_n low SHALL immediately force state to IDLE, counter to 0, and busy, done, div_zero, quotient and remainder to 0.
REQ-026 Reset mid-CALC SHALL abandon the operation; no done SHALL be produced for it.
REQ-027 After rst_n rises, the first start SHALL be accepted on the first rising edge at which start=1.

Structure
REQ-028 FSM state constants and the default WIDTH SHALL live in a shared definitions package/header used by the datapath blocks.
REQ-029 One sub-module div_step (combinational: shift-in, WIDTH+1-bit trial subtract, select, quotient bit out) SHALL implement one iteration; seq_divider32 SHALL hold the FSM, counter and registers.

Verification
REQ-030 Case 1: 100 / 7 -> quotient 14, remainder 2, div_zero 0, done after exactly 33 edges, busy high for 32 cycles.
REQ-031 Case 2: 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0; then 0xFFFFFFFF / 0x80000000 -> quotient 1, remainder 0x7FFFFFFF.
REQ-032 Case 3: 5 / 9 -> quotient 0, remainder 5; then 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x12345678, div_zero 1, done after 1 edge.
REQ-033 Case 4: pulse start with new operands at CALC cycle 10 -> ignored; the original result is unchanged and exactly one done pulse occurs.
REQ-034 Case 5: assert rst_n low at CALC cycle 15 -> all outputs 0 immediately, no done; a following 1000 / 10 -> 100 r 0.
REQ-035 Case 6: 10,000 random operand pairs, including divisor 0 and divisor > dividend, checked against a reference model: dividend = quotient*divisor + remainder and remainder < divisor.
